iq_decimator: RTL and testbench

IQ_DECIMATOR -- requirements
Module: iq_decimator

---
 rtl/iq_decimator_if.sv | 34 +++
 rtl/iq_decimator.sv | 231 +++++++++++++++++++++++
 tb/tb_iq_decimator.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_decimator_if.sv
// iq_decimator_if: run control, mixer input and decimated-output handshake
// bundle for iq_decimator.
//   en, dec_ratio, shift         run enable, ratio N, output right-shift
//   in_i, in_q, in_val           four signed 16-bit lanes per word, qualifier
//   out_i, out_q, out_val        FIFO head sample and its valid flag
//   out_rdy                      consumer accept (pop on out_val & out_rdy)
//   overflow                     sticky "a result was dropped" flag
// master = producer/consumer side (testbench or system), slave = decimator.
interface iq_decimator_if #(
  parameter int unsigned DEC_W = 16,
  parameter int unsigned OUT_W = 32
);
  logic             en;
  logic [DEC_W-1:0] dec_ratio;
  logic [4:0]       shift;
  logic [63:0]      in_i;
  logic [63:0]      in_q;
  logic             in_val;
  logic [OUT_W-1:0] out_i;
  logic [OUT_W-1:0] out_q;
  logic             out_val;
  logic             out_rdy;
  logic             overflow;

  modport master (
    output en, dec_ratio, shift, in_i, in_q, in_val, out_rdy,
    input  out_i, out_q, out_val, overflow
  );

  modport slave (
    input  en, dec_ratio, shift, in_i, in_q, in_val, out_rdy,
    output out_i, out_q, out_val, overflow
  );
endinterface

// File: rtl/iq_decimator.sv
// iq_decimator: sums N valid mixer words (four I lanes and four Q lanes each),
// scales the total by an arithmetic right-shift with saturation to OUT_W and
// queues the result in a first-word-fall-through FIFO.
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   bus (slave)  iq_decimator_if: en, dec_ratio, shift, in_i, in_q, in_val,
//                out_i, out_q, out_val, out_rdy, overflow
// Optional build macro: IQ_DEC_ROUND_EN adds 2^(shift-1) before the shift
// (round half up); without it the shift truncates toward -inf.
// FIFO_DEPTH must be a power of two, at least 2.
module iq_decimator #(
  parameter int unsigned DEC_W      = 16,
  parameter int unsigned ACC_W      = 34,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  iq_decimator_if.slave bus
);

  localparam int unsigned LANE_W = 16;
  localparam int unsigned LSUM_W = 18;          // four 16-bit lanes
  localparam int unsigned SUM_W  = ACC_W + 1;   // one guard bit for rounding
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  typedef struct packed {
    logic [OUT_W-1:0] q;
    logic [OUT_W-1:0] i;
  } sample_t;

  // Sign-extended sum of the four 16-bit lanes of one word.
  function automatic logic signed [LSUM_W-1:0] lane_sum(input logic [63:0] w);
    logic signed [LSUM_W-1:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      s = s + LSUM_W'($signed(w[k*LANE_W +: LANE_W]));
    end
    return s;
  endfunction

  // total >>> sh (optionally rounded), clamped to the signed OUT_W range.
  function automatic logic [OUT_W-1:0] scale(input logic signed [ACC_W-1:0] total,
                                             input logic [4:0]              sh);
    logic signed [SUM_W-1:0] t;
    logic signed [SUM_W-1:0] r;
    logic [SUM_W-OUT_W:0]    top;
    t = SUM_W'(total);
`ifdef IQ_DEC_ROUND_EN
    if (sh != 5'd0) begin
      t = t + (SUM_W'(1) << (sh - 5'd1));
    end
`endif
    r   = t >>> sh;
    top = r[SUM_W-1:OUT_W-1];
    // Fits when every bit above the OUT_W sign bit matches it.
    if ((&top) || !(|top)) begin
      return r[OUT_W-1:0];
    end else if (r[SUM_W-1]) begin
      return {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0] total_i_c, total_q_c;
  logic [DEC_W-1:0]        cnt_q, cnt_d;
  logic [DEC_W-1:0]        n_last_q, n_last_d;
  logic [4:0]              shift_q, shift_d;
  logic                    dump_c;

  logic                    stg_val_q;
  sample_t                 stg_q, stg_d;

  sample_t                 mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  sample_t                 head_q, head_d;
  logic                    out_val_q;
  logic                    overflow_q, overflow_d;
  logic                    push_c, pop_c, full_c, wr_en_c;

  // Running totals including the current word.
  assign total_i_c = acc_i_q + ACC_W'(lane_sum(bus.in_i));
  assign total_q_c = acc_q_q + ACC_W'(lane_sum(bus.in_q));

  // Accumulate FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      cnt_q    <= '0;
      n_last_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      cnt_q    <= cnt_d;
      n_last_q <= n_last_d;
      shift_q  <= shift_d;
    end
  end

  // Accumulate FSM next state; dump_c marks the last word of a block.
  always_comb begin
    state_d  = state_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    cnt_d    = cnt_q;
    n_last_d = n_last_q;
    shift_d  = shift_q;
    dump_c   = 1'b0;
    case (state_q)
      IDLE: begin
        acc_i_d = '0;
        acc_q_d = '0;
        cnt_d   = '0;
        if (bus.en) begin
          state_d  = ACCUM;
          // Ratio 0 behaves as ratio 1: every word is the last of its block.
          n_last_d = (bus.dec_ratio == '0) ? '0 : bus.dec_ratio - DEC_W'(1);
          shift_d  = bus.shift;
        end
      end
      ACCUM: begin
        if (!bus.en) begin
          state_d = IDLE;
          acc_i_d = '0;
          acc_q_d = '0;
          cnt_d   = '0;
        end else if (bus.in_val) begin
          if (cnt_q == n_last_q) begin
            dump_c  = 1'b1;
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
          end else begin
            acc_i_d = total_i_c;
            acc_q_d = total_q_c;
            cnt_d   = cnt_q + DEC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: scaled, saturated block total.
  always_comb begin
    stg_d   = stg_q;
    stg_d.i = scale(total_i_c, shift_q);
    stg_d.q = scale(total_q_c, shift_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_val_q <= 1'b0;
      stg_q     <= '0;
    end else begin
      stg_val_q <= dump_c;
      if (dump_c) begin
        stg_q <= stg_d;
      end
    end
  end

  // FIFO control; the head is pre-computed so out_i/out_q come from flops.
  always_comb begin
    push_c   = stg_val_q;
    pop_c    = out_val_q & bus.out_rdy;
    full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves the same cycle.
    wr_en_c  = push_c & (~full_c | pop_c);
    rd_ptr_d = pop_c   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0) begin
      head_d = '0;
    end else if (wr_en_c && (wr_ptr_q == rd_ptr_d)) begin
      head_d = stg_q;   // entry being written becomes the head
    end else begin
      head_d = mem[rd_ptr_d];
    end
    overflow_d = overflow_q | (push_c & full_c & ~pop_c);
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= stg_q;
    end
  end

  // FIFO pointers, occupancy and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      out_val_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      out_val_q  <= (count_d != '0);
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_i    = head_q.i;
  assign bus.out_q    = head_q.q;
  assign bus.out_val  = out_val_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_iq_decimator.sv
// tb_iq_decimator: randomized and directed checks of iq_decimator against a
// plain-arithmetic reference (lane sums, shift, clamp) kept in this file.
module tb_iq_decimator;

  localparam int unsigned DEC_W = 16;
  localparam int unsigned ACC_W = 34;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  logic [31:0] obs_i[$];
  logic [31:0] obs_q[$];
  int          obs_t[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iq_decimator_if #(.DEC_W(DEC_W), .OUT_W(OUT_W)) bus ();

  iq_decimator #(
    .DEC_W(DEC_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Record every accepted output with the cycle it was presented.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_val === 1'b1 && bus.out_rdy === 1'b1) begin
      obs_i.push_back(bus.out_i);
      obs_q.push_back(bus.out_q);
      obs_t.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  function automatic longint lanes_sum(input logic [63:0] w);
    longint s;
    logic [15:0] lane;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      lane = w[k*16 +: 16];
      s += longint'($signed(lane));
    end
    return s;
  endfunction

  function automatic logic [31:0] ref_scale(input longint total, input int sh);
    longint t;
    t = total;
`ifdef IQ_DEC_ROUND_EN
    if (sh > 0) t = t + (longint'(1) <<< (sh - 1));
`endif
    t = t >>> sh;
    if (t > 64'sd2147483647) t = 64'sd2147483647;
    else if (t < -64'sd2147483648) t = -64'sd2147483648;
    return t[31:0];
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en        = 1'b0;
    bus.in_val    = 1'b0;
    bus.in_i      = '0;
    bus.in_q      = '0;
    bus.dec_ratio = DEC_W'(1);
    bus.shift     = 5'd0;
    bus.out_rdy   = 1'b1;
  endtask

  task automatic clear_q();
    obs_i.delete(); obs_q.delete(); obs_t.delete();
    exp_i.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    clear_q();
  endtask

  task automatic start_run(input int n, input int sh);
    bus.dec_ratio = DEC_W'(n);
    bus.shift     = 5'(sh);
    bus.en        = 1'b1;
    bus.in_val    = 1'b0;
    tick();
  endtask

  task automatic drive(input logic [63:0] wi, input logic [63:0] wq);
    bus.in_val = 1'b1;
    bus.in_i   = wi;
    bus.in_q   = wq;
    tick();
  endtask

  task automatic compare_all(input string name);
    n_cmp++;
    if (obs_i.size() != exp_i.size()) begin
      n_bad++;
      $display("FAIL %s_count: got %0d results, want %0d", name, obs_i.size(), exp_i.size());
    end
    for (int k = 0; k < obs_i.size() && k < exp_i.size(); k++) begin
      n_cmp++;
      if (obs_i[k] !== exp_i[k] || obs_q[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL %s[%0d]: got i=%0d q=%0d, want i=%0d q=%0d", name, k,
                 $signed(obs_i[k]), $signed(obs_q[k]), $signed(exp_i[k]), $signed(exp_q[k]));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.in_val = 1'b1; bus.dec_ratio = DEC_W'(1);
    bus.in_i = {$urandom, $urandom}; bus.in_q = {$urandom, $urandom};
    bus.out_rdy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (bus.out_val !== 1'b0) begin n_bad++; $display("FAIL rst_out_val: got %b want 0", bus.out_val); end
    n_cmp++; if (bus.out_i !== 32'd0) begin n_bad++; $display("FAIL rst_out_i: got %h want 0", bus.out_i); end
    n_cmp++; if (bus.out_q !== 32'd0) begin n_bad++; $display("FAIL rst_out_q: got %h want 0", bus.out_q); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
    rst = 1'b0;
    idle_inputs();
    tick();
    @(negedge clk);
    n_cmp++; if (bus.out_val !== 1'b0 || bus.overflow !== 1'b0) begin
      n_bad++; $display("FAIL post_rst: got out_val=%b overflow=%b want 0 0", bus.out_val, bus.overflow);
    end
    tick();
  endtask

  task automatic test_basic();
    int t_last;
    do_reset();
    start_run(4, 0);
    t_last = 0;
    for (int j = 0; j < 4; j++) begin
      t_last = cyc;
      drive(pack4(100, 100, 100, 100), pack4(-50, -50, -50, -50));
    end
    bus.in_val = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_val !== 1'b0) begin n_bad++; $display("FAIL basic_early: got out_val=%b want 0", bus.out_val); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.out_val !== 1'b1 || bus.out_i !== 32'd1600 || bus.out_q !== 32'hFFFF_FCE0) begin
      n_bad++; $display("FAIL basic_out: got val=%b i=%0d q=%0d want 1 1600 -800",
                        bus.out_val, $signed(bus.out_i), $signed(bus.out_q));
    end
    repeat (3) tick();
    n_cmp++; if (obs_t.size() != 1 || obs_t[0] != t_last + 2) begin
      n_bad++; $display("FAIL basic_latency: got %0d results first at %0d, want 1 at %0d",
                        obs_t.size(), (obs_t.size() > 0) ? obs_t[0] : -1, t_last + 2);
    end
  endtask

  task automatic test_stream();
    int t0;
    logic [63:0] wq;
    do_reset();
    start_run(1, 0);
    t0 = cyc;
    for (int j = 0; j < 8; j++) begin
      wq = {$urandom, $urandom};
      exp_i.push_back(32'd10);
      exp_q.push_back(ref_scale(lanes_sum(wq), 0));
      drive(pack4(1, 2, 3, 4), wq);
    end
    bus.in_val = 1'b0;
    repeat (4) tick();
    compare_all("stream");
    for (int k = 0; k < obs_t.size(); k++) begin
      n_cmp++;
      if (obs_t[k] != t0 + 2 + k) begin
        n_bad++; $display("FAIL stream_timing[%0d]: got cycle %0d want %0d", k, obs_t[k], t0 + 2 + k);
      end
    end
  endtask

  task automatic test_zero_ratio();
    logic [63:0] wi, wq;
    do_reset();
    start_run(0, 0);
    for (int j = 0; j < 3; j++) begin
      wi = {$urandom, $urandom}; wq = {$urandom, $urandom};
      exp_i.push_back(ref_scale(lanes_sum(wi), 0));
      exp_q.push_back(ref_scale(lanes_sum(wq), 0));
      drive(wi, wq);
    end
    bus.in_val = 1'b0;
    repeat (4) tick();
    compare_all("zero_ratio");
  endtask

  task automatic test_round();
    do_reset();
    start_run(1, 2);
`ifdef IQ_DEC_ROUND_EN
    exp_i.push_back(32'd2);
`else
    exp_i.push_back(32'd1);
`endif
    exp_q.push_back(ref_scale(-6, 2));
    drive(pack4(1, 2, 3, 0), pack4(-1, -2, -3, 0));
    bus.in_val = 1'b0;
    repeat (4) tick();
    compare_all("round");
  endtask

  task automatic test_abort();
    do_reset();
    start_run(8, 0);
    repeat (3) drive(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    bus.en = 1'b0; bus.in_val = 1'b0;
    tick();
    start_run(8, 0);
    repeat (8) drive(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    bus.in_val = 1'b0;
    repeat (4) tick();
    exp_i.push_back(32'd32);
    exp_q.push_back(32'd32);
    compare_all("abort");
  endtask

  task automatic test_overflow();
    logic [63:0] wi, wq;
    do_reset();
    bus.out_rdy = 1'b0;
    start_run(1, 0);
    for (int j = 0; j < 5; j++) begin
      wi = {$urandom, $urandom}; wq = {$urandom, $urandom};
      if (j < 4) begin
        exp_i.push_back(ref_scale(lanes_sum(wi), 0));
        exp_q.push_back(ref_scale(lanes_sum(wq), 0));
      end
      drive(wi, wq);
    end
    bus.in_val = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    n_cmp++; if (bus.out_val !== 1'b1 || bus.out_i !== exp_i[0]) begin
      n_bad++; $display("FAIL ovf_head: got val=%b i=%h want 1 %h", bus.out_val, bus.out_i, exp_i[0]);
    end
    tick();
    bus.out_rdy = 1'b1;
    repeat (8) tick();
    compare_all("ovf_drain");
    @(negedge clk);
    n_cmp++; if (bus.overflow !== 1'b1 || bus.out_val !== 1'b0) begin
      n_bad++; $display("FAIL ovf_sticky: got overflow=%b out_val=%b want 1 0", bus.overflow, bus.out_val);
    end
    tick();
  endtask

  task automatic test_full_push_pop();
    logic [63:0] wi, wq;
    do_reset();
    bus.out_rdy = 1'b0;
    start_run(1, 0);
    for (int j = 0; j < 6; j++) begin
      if (j == 5) bus.out_rdy = 1'b1;
      wi = {$urandom, $urandom}; wq = {$urandom, $urandom};
      exp_i.push_back(ref_scale(lanes_sum(wi), 0));
      exp_q.push_back(ref_scale(lanes_sum(wq), 0));
      drive(wi, wq);
    end
    bus.in_val = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL full_pp_overflow: got %b want 0", bus.overflow); end
    compare_all("full_push_pop");
    tick();
  endtask

  task automatic test_reset_mid();
    logic [63:0] wi, wq;
    do_reset();
    bus.out_rdy = 1'b0;
    start_run(1, 0);
    repeat (5) drive({$urandom, $urandom}, {$urandom, $urandom});
    bus.in_val = 1'b0;
    repeat (3) tick();
    bus.en = 1'b0;
    tick();
    start_run(2, 0);
    drive({$urandom, $urandom}, {$urandom, $urandom});
    bus.in_val = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.overflow !== 1'b1 || bus.out_val !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre: got overflow=%b out_val=%b want 1 1", bus.overflow, bus.out_val);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (bus.out_val !== 1'b0 || bus.overflow !== 1'b0 || bus.out_i !== 32'd0) begin
      n_bad++; $display("FAIL mid_rst: got val=%b ovf=%b i=%h want 0 0 0", bus.out_val, bus.overflow, bus.out_i);
    end
    tick();
    rst = 1'b0;
    clear_q();
    bus.out_rdy = 1'b1;
    start_run(2, 0);
    wi = {$urandom, $urandom}; wq = {$urandom, $urandom};
    drive(wi, wq);
    exp_i.push_back(ref_scale(lanes_sum(wi) + lanes_sum(64'h0001_0002_0003_0004), 0));
    exp_q.push_back(ref_scale(lanes_sum(wq) + lanes_sum(64'hFFFF_FFFF_FFFF_FFFF), 0));
    drive(64'h0001_0002_0003_0004, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.in_val = 1'b0;
    repeat (4) tick();
    compare_all("mid_after");
  endtask

  task automatic test_random(input bit throttle);
    int n, sh, cnt;
    longint ai, aq;
    logic [63:0] wi, wq;
    for (int b = 0; b < 3; b++) begin
      do_reset();
      n  = throttle ? int'($urandom_range(7, 4)) : int'($urandom_range(6, 1));
      sh = throttle ? int'($urandom_range(8, 0)) : int'($urandom_range(31, 0));
      ai = 0; aq = 0; cnt = 0;
      start_run(n, sh);
      for (int c = 0; c < 48; c++) begin
        // out_rdy is forced high every 4th cycle so the FIFO never fills.
        if (throttle) bus.out_rdy = ((c % 4) == 3) ? 1'b1 : 1'($urandom_range(1, 0));
        if ($urandom_range(3, 0) != 0) begin
          wi = {$urandom, $urandom}; wq = {$urandom, $urandom};
          ai += lanes_sum(wi); aq += lanes_sum(wq); cnt++;
          if (cnt == n) begin
            exp_i.push_back(ref_scale(ai, sh));
            exp_q.push_back(ref_scale(aq, sh));
            ai = 0; aq = 0; cnt = 0;
          end
          drive(wi, wq);
        end else begin
          bus.in_val = 1'b0;
          tick();
        end
      end
      bus.in_val  = 1'b0;
      bus.out_rdy = 1'b1;
      repeat (8) tick();
      compare_all(throttle ? "rand_throttled" : "rand");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    start_run(65535, 0);
    for (int j = 0; j < 65535; j++) begin
      drive(pack4(32767, 32767, 32767, 32767), pack4(-32768, -32768, -32768, -32768));
    end
    bus.in_val = 1'b0;
    repeat (4) tick();
    exp_i.push_back(32'h7FFF_FFFF);
    exp_q.push_back(32'h8000_0000);
    compare_all("saturation");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_basic();
    test_stream();
    test_zero_ratio();
    test_round();
    test_abort();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random(1'b0);
    test_random(1'b1);
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
